// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Signal names carry the LSU's direction so they read the same on both sides.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: turns one load/store into a req/gnt/rvalid bus transaction,
// stalls the core meanwhile and returns aligned, extended load data.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_byte_i,
    input  logic              zero_extnd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wr_data_i,
    output logic              stall_o,
    output logic [31:0]       rd_data_o,
    output logic              rd_valid_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    load_store_unit_if.master mem
);
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e            state_q;
    logic [7:0]        tmo_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              zext_q;
    logic              wr_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;
    logic              misalign_q;
    logic              bus_err_q;

    logic              legal_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic              complete_d;
    logic              abort_d;

    function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        zext);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: align_load = zext ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: align_load = zext ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: align_load = rdata;
        endcase
    endfunction

    always_comb begin
        legal_d = 1'b0;
        be_d    = 4'b1111;
        case (data_byte_i)
            SZ_BYTE: begin
                legal_d = 1'b1;
                be_d    = 4'b0001 << addr_i[1:0];
            end
            SZ_HALF: begin
                legal_d = ~addr_i[0];
                be_d    = 4'b0011 << addr_i[1:0];
            end
            SZ_WORD: legal_d = (addr_i[1:0] == 2'b00);
            default: legal_d = 1'b0;
        endcase
        wdata_d = wr_data_i << {addr_i[1:0], 3'b000};

        // A same-cycle gnt+rvalid in REQ finishes the access without visiting WAIT.
        complete_d = 1'b0;
        if (state_q == S_REQ) begin
            complete_d = mem.mem_gnt_i & mem.mem_rvalid_i;
        end else if (state_q == S_WAIT) begin
            complete_d = mem.mem_rvalid_i;
        end
        abort_d = ((state_q == S_REQ) || (state_q == S_WAIT)) && !complete_d &&
                  (tmo_q == TMO_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            tmo_q       <= 8'd0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            zext_q      <= 1'b0;
            wr_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
            rd_data_q   <= 32'd0;
            rd_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (data_req_i) begin
                        if (legal_d) begin
                            state_q     <= S_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= data_wr_i;
                            mem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            size_q      <= data_byte_i;
                            off_q       <= addr_i[1:0];
                            zext_q      <= zero_extnd_i;
                            wr_q        <= data_wr_i;
                        end else begin
                            state_q    <= S_DONE;
                            misalign_q <= 1'b1;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    if (complete_d) begin
                        state_q    <= S_DONE;
                        tmo_q      <= 8'd0;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        rd_valid_q <= 1'b1;
                        if (!wr_q) begin
                            rd_data_q <= align_load(mem.mem_rdata_i, off_q, size_q, zext_q);
                        end
                    end else if (abort_d) begin
                        state_q   <= S_DONE;
                        tmo_q     <= 8'd0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                        if ((state_q == S_REQ) && mem.mem_gnt_i) begin
                            state_q   <= S_WAIT;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The core's request is reflected immediately so the PC holds in the request cycle.
    assign stall_o = rst_ni & (((state_q == S_IDLE) & data_req_i) |
                               (state_q == S_REQ) | (state_q == S_WAIT));

    assign rd_data_o       = rd_data_q;
    assign rd_valid_o      = rd_valid_q;
    assign misalign_o      = misalign_q;
    assign bus_err_o       = bus_err_q;
    assign mem.mem_req_o   = mem_req_q;
    assign mem.mem_we_o    = mem_we_q;
    assign mem.mem_addr_o  = mem_addr_q;
    assign mem.mem_be_o    = mem_be_q;
    assign mem.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus a randomized back-to-back run
// checked against a size/offset arithmetic model and a reactive memory responder.
module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_byte;
    logic        zero_extnd;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        misalign;
    logic        bus_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_rd;

    // Per-access observations gathered by run_access.
    int          r_stall;
    int          r_req;
    logic        r_done;
    logic        r_valid;
    logic        r_mis;
    logic        r_err;
    logic [31:0] r_rd;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_req_done;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_req_i   (data_req),
        .data_wr_i    (data_wr),
        .data_byte_i  (data_byte),
        .zero_extnd_i (zero_extnd),
        .addr_i       (addr),
        .wr_data_i    (wr_data),
        .stall_o      (stall),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .misalign_o   (misalign),
        .bus_err_o    (bus_err),
        .mem          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one access and plays memory: grant after gnt_dly request cycles (-1 = never),
    // response rv_dly cycles after the grant. Stops at the DONE pulse or after 60 cycles.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic zx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        int gcyc;
        gcyc = -1;
        r_stall = 0; r_req = 0; r_done = 0; r_valid = 0; r_mis = 0; r_err = 0;
        r_rd = '0; r_addr = '0; r_be = '0; r_wdata = '0; r_we = 0; r_req_done = 0;
        @(posedge clk); #1;
        data_req = 1; data_wr = wr; data_byte = sz; zero_extnd = zx; addr = a; wr_data = wd;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            bus.mem_gnt_i    = 0;
            bus.mem_rvalid_i = 0;
            bus.mem_rdata_i  = $urandom;
            if (bus.mem_req_o) begin
                if (r_req == 0) begin
                    r_addr = bus.mem_addr_o; r_be = bus.mem_be_o;
                    r_wdata = bus.mem_wdata_o; r_we = bus.mem_we_o;
                end
                if (gnt_dly >= 0 && r_req == gnt_dly) begin
                    bus.mem_gnt_i = 1;
                    gcyc = k;
                end
                r_req++;
            end
            if (gcyc >= 0 && k == gcyc + rv_dly) begin
                bus.mem_rvalid_i = 1;
                bus.mem_rdata_i  = rdata;
            end
            @(negedge clk);
            if (stall) r_stall++;
            if (rd_valid || misalign || bus_err) begin
                r_done = 1; r_valid = rd_valid; r_mis = misalign; r_err = bus_err;
                r_rd = rd_data; r_req_done = bus.mem_req_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; data_req = 1; data_wr = 0; data_byte = 2'b10; zero_extnd = 0;
        addr = 32'h100; wr_data = 32'h0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 32'h0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({stall, rd_valid, misalign, bus_err, bus.mem_req_o, bus.mem_we_o} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {stall, rd_valid, misalign, bus_err, bus.mem_req_o, bus.mem_we_o});
        else n_pass++;
        n_total++;
        if ({rd_data, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o} !== 100'd0)
            $display("FAIL reset_data: rd %h addr %h be %b wdata %h want all 0",
                     rd_data, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o);
        else n_pass++;
        data_req = 0;
        rst_n = 1;
        exp_rd = 32'h0;
    endtask

    task automatic test_lw();
        run_access(0, 2'b10, 0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        exp_rd = 32'hDEADBEEF;
        n_total++;
        if (r_done !== 1'b1) $display("FAIL lw_done: got %b want 1", r_done); else n_pass++;
        n_total++;
        if (r_addr !== 32'h100) $display("FAIL lw_addr: got %h want 00000100", r_addr); else n_pass++;
        n_total++;
        if (r_be !== 4'b1111) $display("FAIL lw_be: got %b want 1111", r_be); else n_pass++;
        n_total++;
        if (r_rd !== exp_rd || r_valid !== 1'b1)
            $display("FAIL lw_data: got %h/%b want %h/1", r_rd, r_valid, exp_rd);
        else n_pass++;
        n_total++;
        if (r_stall != 3) $display("FAIL lw_stall: got %0d want 3", r_stall); else n_pass++;
    endtask

    task automatic test_lb_lbu();
        run_access(0, 2'b00, 0, 32'h203, 32'h0, 0, 1, 32'h80FF_0000);
        n_total++;
        if (r_rd !== 32'hFFFFFF80 || r_be !== 4'b1000 || r_addr !== 32'h200)
            $display("FAIL lb: rd %h be %b addr %h want ffffff80 1000 00000200", r_rd, r_be, r_addr);
        else n_pass++;
        run_access(0, 2'b00, 1, 32'h203, 32'h0, 0, 1, 32'h80FF_0000);
        exp_rd = 32'h00000080;
        n_total++;
        if (r_rd !== exp_rd || r_be !== 4'b1000)
            $display("FAIL lbu: rd %h be %b want 00000080 1000", r_rd, r_be);
        else n_pass++;
    endtask

    task automatic test_sh();
        run_access(1, 2'b01, 0, 32'h12, 32'h0000ABCD, 1, 1, 32'h1234_5678);
        n_total++;
        if (r_addr !== 32'h10 || r_be !== 4'b1100)
            $display("FAIL sh_addr_be: addr %h be %b want 00000010 1100", r_addr, r_be);
        else n_pass++;
        n_total++;
        if (r_wdata[31:16] !== 16'hABCD || r_we !== 1'b1)
            $display("FAIL sh_wdata_we: wdata %h we %b want abcd.... 1", r_wdata, r_we);
        else n_pass++;
        n_total++;
        if (r_valid !== 1'b1 || r_rd !== exp_rd || r_stall != 4)
            $display("FAIL sh_done: valid %b rd %h stall %0d want 1 %h 4", r_valid, r_rd, r_stall, exp_rd);
        else n_pass++;
    endtask

    task automatic test_misalign();
        run_access(0, 2'b10, 0, 32'h102, 32'h0, 0, 1, 32'hCAFEF00D);
        n_total++;
        if (r_req != 0 || r_mis !== 1'b1 || r_valid !== 1'b0 || r_err !== 1'b0 || r_stall != 1)
            $display("FAIL misalign_lw: req %0d mis %b valid %b err %b stall %0d want 0 1 0 0 1",
                     r_req, r_mis, r_valid, r_err, r_stall);
        else n_pass++;
        run_access(0, 2'b11, 0, 32'h100, 32'h0, 0, 1, 32'hCAFEF00D);
        n_total++;
        if (r_req != 0 || r_mis !== 1'b1 || r_valid !== 1'b0 || r_rd !== exp_rd)
            $display("FAIL misalign_rsvd: req %0d mis %b valid %b rd %h want 0 1 0 %h",
                     r_req, r_mis, r_valid, r_rd, exp_rd);
        else n_pass++;
        @(posedge clk); #1;
        data_req = 0;
        @(negedge clk);
        n_total++;
        if (misalign !== 1'b0) $display("FAIL misalign_pulse: got %b want 0", misalign); else n_pass++;
    endtask

    task automatic test_timeout();
        run_access(0, 2'b10, 0, 32'h300, 32'h0, -1, 0, 32'h0);
        n_total++;
        if (r_err !== 1'b1 || r_valid !== 1'b0 || r_done !== 1'b1)
            $display("FAIL tmo_err: err %b valid %b done %b want 1 0 1", r_err, r_valid, r_done);
        else n_pass++;
        n_total++;
        if (r_req != 16 || r_req_done !== 1'b0 || r_stall != 17)
            $display("FAIL tmo_cycles: req %0d req_at_done %b stall %0d want 16 0 17",
                     r_req, r_req_done, r_stall);
        else n_pass++;
        @(posedge clk); #1;
        data_req = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h5555AAAA;
        @(negedge clk);
        n_total++;
        if (rd_valid !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0 || rd_data !== exp_rd)
            $display("FAIL tmo_late_rvalid: valid %b stall %b err %b rd %h want 0 0 0 %h",
                     rd_valid, stall, bus_err, rd_data, exp_rd);
        else n_pass++;
        @(posedge clk); #1;
        bus.mem_rvalid_i = 0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        data_req = 1; data_wr = 0; data_byte = 2'b10; zero_extnd = 0; addr = 32'h40;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
        @(posedge clk); #1;
        bus.mem_gnt_i = bus.mem_req_o;
        @(posedge clk); #1;
        bus.mem_gnt_i = 0;
        n_total++;
        if (stall !== 1'b1 || bus.mem_req_o !== 1'b0)
            $display("FAIL wait_state: stall %b req %b want 1 0", stall, bus.mem_req_o);
        else n_pass++;
        #2 rst_n = 0;
        #1;
        exp_rd = 32'h0;
        n_total++;
        if ({stall, rd_valid, misalign, bus_err, bus.mem_req_o, bus.mem_we_o} !== 6'b0 ||
            {rd_data, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o} !== 100'd0)
            $display("FAIL async_reset: ctrl %b rd %h addr %h be %b wdata %h want all 0",
                     {stall, rd_valid, misalign, bus_err, bus.mem_req_o, bus.mem_we_o},
                     rd_data, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o);
        else n_pass++;
        data_req = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77777777;
        @(negedge clk);
        n_total++;
        if (rd_valid !== 1'b0 || stall !== 1'b0 || rd_data !== exp_rd)
            $display("FAIL rst_late_rvalid: valid %b stall %b rd %h want 0 0 %h",
                     rd_valid, stall, rd_data, exp_rd);
        else n_pass++;
        run_access(0, 2'b10, 0, 32'h104, 32'h0, 0, 1, 32'h12345678);
        exp_rd = 32'h12345678;
        n_total++;
        if (r_rd !== exp_rd || r_valid !== 1'b1 || r_stall != 3 || r_addr !== 32'h104)
            $display("FAIL lw_after_reset: rd %h valid %b stall %0d addr %h want %h 1 3 00000104",
                     r_rd, r_valid, r_stall, r_addr, exp_rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 40; it++) begin
            logic        wr, zx, legal;
            logic [1:0]  sz, off;
            logic [31:0] a, wd, rdv, v, exp_wd;
            logic [3:0]  exp_be;
            int          nb, gd, rv, exp_stall;
            wr  = 1'($urandom_range(0, 1));
            zx  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = 32'h400 + 32'($urandom_range(0, 63));
            wd  = $urandom;
            rdv = $urandom;
            gd  = $urandom_range(0, 3);
            rv  = $urandom_range(0, 2);
            off = a[1:0];
            nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            legal = (sz != 2'd3) && ((a % nb) == 0);
            exp_be = 4'(((1 << nb) - 1) << off);
            exp_wd = wd << (8 * off);
            exp_stall = legal ? (1 + gd + 1 + rv) : 1;
            if (legal && !wr) begin
                v = rdv >> (8 * off);
                if (nb < 4) begin
                    v = v & ((32'd1 << (8 * nb)) - 1);
                    if (!zx && v[8 * nb - 1]) v = v - (32'd1 << (8 * nb));
                end
                exp_rd = v;
            end
            run_access(wr, sz, zx, a, wd, gd, rv, rdv);
            n_total++;
            if ({r_done, r_valid, r_mis, r_err} !== {1'b1, legal, !legal, 1'b0})
                $display("FAIL b2b_flags[%0d]: done/valid/mis/err %b want %b", it,
                         {r_done, r_valid, r_mis, r_err}, {1'b1, legal, !legal, 1'b0});
            else n_pass++;
            n_total++;
            if (r_stall != exp_stall || r_req != (legal ? gd + 1 : 0))
                $display("FAIL b2b_timing[%0d]: stall %0d req %0d want %0d %0d", it,
                         r_stall, r_req, exp_stall, legal ? gd + 1 : 0);
            else n_pass++;
            n_total++;
            if (r_rd !== exp_rd) $display("FAIL b2b_rd[%0d]: got %h want %h", it, r_rd, exp_rd);
            else n_pass++;
            if (legal) begin
                n_total++;
                if (r_addr !== {a[31:2], 2'b00} || r_be !== exp_be || r_we !== wr)
                    $display("FAIL b2b_bus[%0d]: addr %h be %b we %b want %h %b %b", it,
                             r_addr, r_be, r_we, {a[31:2], 2'b00}, exp_be, wr);
                else n_pass++;
                if (wr) begin
                    n_total++;
                    if (r_wdata !== exp_wd)
                        $display("FAIL b2b_wdata[%0d]: got %h want %h", it, r_wdata, exp_wd);
                    else n_pass++;
                end
            end
        end
        @(posedge clk); #1;
        data_req = 0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the control unit. Consumes data_req, data_wr, data_byte and zero_extnd, plus the ALU-computed address and rs2 store data.
- Converts each access into a single request/grant/response transaction on the data-memory bus, with byte enables and lane-shifted write data.
- Stalls the single-cycle core until the transaction finishes, then returns the aligned and extended load data to the writeback mux (rf_wr_data_sel = MEM).
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ+WAIT before the access is aborted with bus_err_o. Legal range 2..255.
- ADDR_W, 32: byte-address width.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  memory access requested (from ctrl unit)
- data_wr_i  in  1  1 = store, 0 = load
- data_byte_i  in  2  access size: 00 BYTE, 01 HALF_WORD, 10 WORD, 11 reserved
- zero_extnd_i  in  1  zero-extend load result (LBU/LHU)
- addr_i  in  ADDR_W  byte address (ALU result)
- wr_data_i  in  32  store data (rs2), right-justified
- stall_o  out  1  hold PC and instruction
- rd_data_o  out  32  load result to writeback mux
- rd_valid_o  out  1  access completed this cycle
- misalign_o  out  1  misaligned or reserved-size access
- bus_err_o  out  1  timeout abort
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write enable
- mem_addr_o  out  ADDR_W  word-aligned address (addr[1:0] forced to 00)
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-shifted write data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid (loads and stores)
- mem_rdata_i  in  32  read word

Behaviour:
- Reset: state IDLE. stall_o, rd_valid_o, misalign_o, bus_err_o, mem_req_o and mem_we_o are 0. rd_data_o, mem_addr_o, mem_be_o and mem_wdata_o are 0. Timeout counter is 0.
- Reset asserted mid-transaction returns to IDLE immediately. Any later mem_rvalid_i is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall_o = data_req_i (combinational).
  - On data_req_i with a legal access: register address, we, be, shifted wdata, size, zero_extnd and addr[1:0]; go to REQ.
  - Illegal access means: HALF_WORD with addr[0]=1, WORD with addr[1:0]≠00, or size 11. For these: no bus request; go to DONE with misalign flag set.
- REQ:
  - mem_req_o = 1 and all bus outputs stable until mem_gnt_i.
  - On mem_gnt_i: go to WAIT. mem_req_o deasserts the following cycle.
  - If mem_gnt_i and mem_rvalid_i arrive in the same cycle, go directly to DONE and capture the data.
- WAIT: on mem_rvalid_i, capture mem_rdata_i and go to DONE.
- Timeout:
  - Counter increments every cycle in REQ or WAIT and clears on leaving them.
  - When it reaches TIMEOUT_CYCLES-1 without completion: abort to DONE with bus_err set and mem_req_o low.
- DONE (exactly one cycle):
  - stall_o = 0.
  - rd_valid_o = 1 unless misaligned or error.
  - misalign_o or bus_err_o pulses.
  - data_req_i is ignored; it still belongs to the completing instruction.
  - Next state is IDLE.
- Latency: a request seen in cycle N drives mem_req_o from N+1. With gnt at N+1 and rvalid at N+2, DONE is at N+3, so stall_o is high for N..N+2.
- Byte enables:
  - BYTE: 1 << addr[1:0].
  - HALF_WORD: 0011 << addr[1:0].
  - WORD: 1111.
- Write data: wr_data_i << (8*addr[1:0]); lower lanes are don't-care, driven as the shifted value.
- Load data:
  - Shift mem_rdata_i >> (8*addr[1:0]), keep 8 or 16 bits.
  - Sign-extend unless zero_extnd.
  - WORD loads pass through unchanged.
  - rd_data_o is registered, valid in the DONE cycle, and holds until the next load completes. Stores do not update it.
- Response handling: mem_rvalid_i and mem_gnt_i are ignored in IDLE and DONE.

Test Plan:
- LW addr 0x100, gnt on 1st REQ cycle, rvalid next cycle with rdata 0xDEADBEEF:
  - mem_addr_o 0x100, mem_be_o 1111.
  - rd_data_o 0xDEADBEEF, rd_valid_o in DONE.
  - stall_o high exactly 3 cycles.
- LB addr 0x203, rdata 0x80FF_0000: rd_data_o 0xFFFFFF80. Same as LBU: 0x00000080. mem_be_o 1000 in both cases.
- SH addr 0x12, wr_data_i 0x0000ABCD:
  - mem_addr_o 0x10, mem_be_o 1100, mem_wdata_o[31:16] 0xABCD, mem_we_o 1.
  - Completes on rvalid; rd_data_o unchanged.
- LW addr 0x102: no mem_req_o, misalign_o one-cycle pulse, rd_valid_o 0. Repeat with data_byte_i 11 for the same result.
- mem_gnt_i held low, TIMEOUT_CYCLES=16:
  - bus_err_o pulses after 16 REQ cycles, mem_req_o drops.
  - A late rvalid in the following IDLE is ignored.
- rst_ni asserted while in WAIT: all outputs 0 asynchronously, state IDLE. The next LW after reset completes normally.
